rv64i_dataflow: RTL and testbench

RV64I datapath for the multicycle core. It holds the program counter and the 32×64-bit integer register file, and contains the immediate generator, ALU, load-extension logic and write-back mux. Every select signal comes from the external control unit. In return the block sends back the decoded instruction fields and the ALU flags, and it drives the instruction-memory and data-memory address and data buses.

---
 rtl/rv64i_pkg.sv | 44 ++++
 rtl/rv64i_dataflow_imm_gen.sv | 32 +++
 rtl/rv64i_dataflow.sv | 163 ++++++++++++++++
 tb/tb_rv64i_dataflow.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64i_pkg.sv
// Shared constants for the RV64I multicycle datapath: opcodes, ALU function
// codes, write-back sources and load sizes, plus a word sign-extension helper.
package rv64i_pkg;

   localparam int XLEN = 64;

   // Major opcodes that carry an immediate
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ALU function select, encoded as funct3
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SR   = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   // Write-back source select
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_IMM  = 2'b11;

   // Load size in read_data_src[1:0]; read_data_src[2] selects sign extension
   localparam logic [1:0] LS_B = 2'b00;
   localparam logic [1:0] LS_H = 2'b01;
   localparam logic [1:0] LS_W = 2'b10;
   localparam logic [1:0] LS_D = 2'b11;

   function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/rv64i_dataflow_imm_gen.sv
// Immediate generator: decodes the instruction format from the opcode and
// returns the sign-extended 64-bit immediate (0 for formats without one).
module imm_gen
   import rv64i_pkg::*;
(
   input  logic [31:0]     instruction,
   output logic [XLEN-1:0] imm
);

   // Format decode by major opcode
   always_comb begin
      // NOTE: default assignment first so every path drives imm and no latch is inferred.
      imm = '0;
      case (instruction[6:0])
         OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR:
            imm = {{52{instruction[31]}}, instruction[31:20]};
         OP_STORE:
            imm = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
         OP_BRANCH:
            imm = {{51{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {{32{instruction[31]}}, instruction[31:12], 12'b0};
         OP_JAL:
            imm = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/rv64i_dataflow.sv
// RV64I datapath for the multicycle core: PC, 32x64 register file, ALU,
// load extender and write-back mux. All selects come from the control unit.
// Optional feature: define RV64I_WORD_OPS_EN to implement 32-bit (W) ALU
// operations on aluy_src; without it aluy_src is ignored.
module rv64i_dataflow
   import rv64i_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic [31:0]     instruction,
   output logic [XLEN-1:0] instruction_address,
   input  logic [XLEN-1:0] read_data,
   output logic [XLEN-1:0] write_data,
   output logic [XLEN-1:0] data_address,
   input  logic            alua_src,
   input  logic            alub_src,
   input  logic            aluy_src,
   input  logic [2:0]      alu_src,
   input  logic            carry_in,
   input  logic            arithmetic,
   input  logic            alupc_src,
   input  logic            pc_src,
   input  logic            pc_enable,
   input  logic [2:0]      read_data_src,
   input  logic [1:0]      write_register_src,
   input  logic            write_register_enable,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic            zero,
   output logic            negative,
   output logic            carry_out,
   output logic            overflow,
   output logic [XLEN-1:0] db_reg_data
);

   logic [XLEN-1:0] pc, next_pc, pc_plus4, pc_target;
   logic [XLEN-1:0] imm, rs1_data, rs2_data, reg_data;
   logic [XLEN-1:0] alu_a, alu_b, b_eff, sum, alu_raw, alu_result;
   logic [XLEN-1:0] shift_src, srl_res, sra_res, load_ext;
   logic [XLEN:0]   add_full;
   logic [5:0]      shamt;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] regs [32];

   // Decoded fields back to the control unit
   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign funct7 = instruction[31:25];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign rd     = instruction[11:7];

   imm_gen u_imm_gen (
      .instruction (instruction),
      .imm         (imm)
   );

   // Program counter: reset dominates the load enable
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset)
         pc <= '0;
      else if (pc_enable)
         pc <= next_pc;
   end

   // Register file: reset clears every entry, writes to x0 are dropped
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: resetting the whole array forces it into flops; it cannot map onto a RAM macro.
         for (int i = 0; i < 32; i++)
            regs[i] <= '0;
      end else if (write_register_enable && rd != 5'd0) begin
         regs[rd] <= reg_data;
      end
   end

   assign rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2];

   // Adder and flags; subtraction is A + ~B + 1
   assign alu_a    = alua_src ? pc : rs1_data;
   assign alu_b    = alub_src ? imm : rs2_data;
   assign b_eff    = alu_b ^ {XLEN{carry_in}};
   assign add_full = {1'b0, alu_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, carry_in};
   assign sum       = add_full[XLEN-1:0];
   assign carry_out = add_full[XLEN];
   assign zero      = (sum == '0);
   assign negative  = sum[XLEN-1];
   assign overflow  = (alu_a[XLEN-1] == b_eff[XLEN-1]) & (alu_a[XLEN-1] != sum[XLEN-1]);

`ifdef RV64I_WORD_OPS_EN
   // W mode: 5-bit shift amount, right shifts see a 32-bit operand, result re-extended from bit 31
   assign shamt      = aluy_src ? {1'b0, alu_b[4:0]} : alu_b[5:0];
   assign shift_src  = !aluy_src ? alu_a
                     : arithmetic ? sext_word(alu_a[31:0]) : {32'b0, alu_a[31:0]};
   assign alu_result = aluy_src ? sext_word(alu_raw[31:0]) : alu_raw;
`else
   logic unused_aluy;
   assign unused_aluy = aluy_src;
   assign shamt       = alu_b[5:0];
   assign shift_src   = alu_a;
   assign alu_result  = alu_raw;
`endif

   assign srl_res = shift_src >> shamt;
   assign sra_res = $signed(shift_src) >>> shamt;

   // ALU function select
   always_comb begin
      alu_raw = sum;
      case (alu_src)
         ALU_ADD:  alu_raw = sum;
         ALU_SLL:  alu_raw = alu_a << shamt;
         ALU_SLT:  alu_raw = {{(XLEN-1){1'b0}}, negative ^ overflow};
         ALU_SLTU: alu_raw = {{(XLEN-1){1'b0}}, ~carry_out};
         ALU_XOR:  alu_raw = alu_a ^ alu_b;
         ALU_SR:   alu_raw = arithmetic ? sra_res : srl_res;
         ALU_OR:   alu_raw = alu_a | alu_b;
         ALU_AND:  alu_raw = alu_a & alu_b;
         default:  alu_raw = sum;
      endcase
   end

   // Load extender: pick the low byte/half/word/double, then sign- or zero-extend
   always_comb begin
      load_ext = read_data;
      case (read_data_src[1:0])
         LS_B: load_ext = read_data_src[2] ? {{56{read_data[7]}}, read_data[7:0]}
                                           : {56'b0, read_data[7:0]};
         LS_H: load_ext = read_data_src[2] ? {{48{read_data[15]}}, read_data[15:0]}
                                           : {48'b0, read_data[15:0]};
         LS_W: load_ext = read_data_src[2] ? {{32{read_data[31]}}, read_data[31:0]}
                                           : {32'b0, read_data[31:0]};
         LS_D: load_ext = read_data;
         default: load_ext = read_data;
      endcase
   end

   // Write-back source mux
   always_comb begin
      reg_data = alu_result;
      case (write_register_src)
         WB_ALU:  reg_data = alu_result;
         WB_LOAD: reg_data = load_ext;
         WB_PC4:  reg_data = pc_plus4;
         WB_IMM:  reg_data = imm;
         default: reg_data = alu_result;
      endcase
   end

   // Next PC: sequential, PC-relative target, or register target with bit 0 cleared
   assign pc_plus4  = pc + 64'd4;
   assign pc_target = alupc_src ? {alu_result[XLEN-1:1], 1'b0} : pc + imm;
   assign next_pc   = pc_src ? pc_target : pc_plus4;

   assign instruction_address = pc;
   assign data_address        = alu_result;
   assign write_data          = rs2_data;
   assign db_reg_data         = reg_data;

endmodule

// File: tb/tb_rv64i_dataflow.sv
// Self-checking bench for rv64i_dataflow: directed steps from the datapath
// rules, then randomized ALU traffic against an arithmetic reference model.
module tb_rv64i_dataflow;
   import rv64i_pkg::*;

`ifdef RV64I_WORD_OPS_EN
   localparam bit WORD_EN = 1'b1;
`else
   localparam bit WORD_EN = 1'b0;
`endif
   localparam logic [6:0] OP_REG = 7'b0110011;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [63:0] instruction_address, read_data, write_data, data_address, db_reg_data;
   logic        alua_src, alub_src, aluy_src, carry_in, arithmetic, alupc_src;
   logic        pc_src, pc_enable, write_register_enable;
   logic [2:0]  alu_src, read_data_src, funct3;
   logic [1:0]  write_register_src;
   logic [6:0]  opcode, funct7;
   logic        zero, negative, carry_out, overflow;

   int checks = 0;
   int errors = 0;
   logic [63:0] mregs [32];
   logic [63:0] mpc;

   rv64i_dataflow dut (
      .clock(clock), .reset(reset), .instruction(instruction),
      .instruction_address(instruction_address), .read_data(read_data),
      .write_data(write_data), .data_address(data_address),
      .alua_src(alua_src), .alub_src(alub_src), .aluy_src(aluy_src),
      .alu_src(alu_src), .carry_in(carry_in), .arithmetic(arithmetic),
      .alupc_src(alupc_src), .pc_src(pc_src), .pc_enable(pc_enable),
      .read_data_src(read_data_src), .write_register_src(write_register_src),
      .write_register_enable(write_register_enable),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
      .db_reg_data(db_reg_data)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      check(tag, {63'b0, obs}, {63'b0, exp});
   endtask

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {im, r1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, r2, r1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3);
      return {im[11:5], r2, r1, f3, im[4:0], OP_STORE};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3);
      return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], OP_BRANCH};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd, input logic [6:0] op);
      return {im, rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
      return {im[20], im[10:1], im[11], im[19:12], rd, OP_JAL};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // op: 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and
   function automatic logic [2:0] op_f3(input int op);
      case (op)
         0, 1: return 3'd0;
         2: return 3'd1;
         3: return 3'd2;
         4: return 3'd3;
         5: return 3'd4;
         6, 7: return 3'd5;
         8: return 3'd6;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [63:0] ref_alu(input int op, input logic [63:0] a, input logic [63:0] b, input logic w);
      logic [63:0] r;
      logic signed [31:0] sw;
      logic signed [63:0] sa;
      r = '0;
      case (op)
         0: r = w ? sx32(a[31:0] + b[31:0]) : a + b;
         1: r = w ? sx32(a[31:0] - b[31:0]) : a - b;
         2: r = w ? sx32(a[31:0] << b[4:0]) : a << b[5:0];
         3: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4: r = (a < b) ? 64'd1 : 64'd0;
         5: r = a ^ b;
         6: r = w ? sx32(a[31:0] >> b[4:0]) : a >> b[5:0];
         7: begin
            if (w) begin
               sw = $signed(a[31:0]) >>> b[4:0];
               r = sx32(sw);
            end else begin
               sa = $signed(a) >>> b[5:0];
               r = sa;
            end
         end
         8: r = a | b;
         default: r = a & b;
      endcase
      if (w) r = sx32(r[31:0]);
      return r;
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] sel);
      int w;
      logic [63:0] v;
      logic signed [63:0] s;
      w = 8 << sel[1:0];
      v = d << (64 - w);
      s = $signed(v) >>> (64 - w);
      if (sel[2]) return s;
      return v >> (64 - w);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic defaults();
      reset = 1'b0; instruction = '0; read_data = '0;
      alua_src = 0; alub_src = 0; aluy_src = 0; alu_src = ALU_ADD; carry_in = 0;
      arithmetic = 0; alupc_src = 0; pc_src = 0; pc_enable = 0;
      read_data_src = 3'b000; write_register_src = WB_ALU; write_register_enable = 0;
   endtask

   task automatic begin_step();
      @(negedge clock);
      defaults();
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_write(input logic [4:0] rd, input logic [63:0] v);
      if (rd != 5'd0) mregs[rd] = v;
   endtask

   // Reads a register through the rs2 -> write_data path with all enables off
   task automatic read_reg(input logic [4:0] r);
      defaults();
      instruction = enc_r(7'd0, r, 5'd0, 3'd0, 5'd0, OP_REG);
      #1;
      check($sformatf("x%0d", r), write_data, mregs[r]);
   endtask

   logic [2:0] load_sel [7] = '{3'b100, 3'b000, 3'b101, 3'b001, 3'b110, 3'b010, 3'b011};

   initial begin
      defaults();
      reset = 1'b1;
      tick();
      mpc = '0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;

      // Post-reset state
      begin_step();
      settle();
      check("reset_pc", instruction_address, 64'd0);
      check("reset_db", db_reg_data, 64'd0);
      check_bit("reset_zero", zero, 1'b1);

      // ADDI x1,x0,-5
      begin_step();
      instruction = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, OP_IMM);
      alub_src = 1; write_register_enable = 1; pc_enable = 1;
      settle();
      check("addi_db", db_reg_data, 64'hFFFF_FFFF_FFFF_FFFB);
      check("addi_opcode", {57'b0, opcode}, {57'b0, OP_IMM});
      tick();
      model_write(5'd1, 64'hFFFF_FFFF_FFFF_FFFB); mpc = 64'd4;
      check("addi_pc", instruction_address, mpc);
      read_reg(5'd1);

      // ADDI x2,x0,3
      begin_step();
      instruction = enc_i(12'd3, 5'd0, 3'd0, 5'd2, OP_IMM);
      alub_src = 1; write_register_enable = 1; pc_enable = 1;
      tick();
      model_write(5'd2, 64'd3); mpc = 64'd8;
      check("addi2_pc", instruction_address, mpc);

      // SUB x1 - x2 flags, then SLT / SLTU
      begin_step();
      instruction = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, OP_REG);
      carry_in = 1;
      settle();
      check("sub_flags", {61'b0, negative, overflow, zero}, 64'b100);
      check("sub_fields", {54'b0, funct7, funct3}, {54'b0, 7'h20, 3'd0});
      alu_src = ALU_SLTU;
      settle();
      check("sltu_db", db_reg_data, 64'd0);
      check_bit("sltu_carry", carry_out, 1'b1);
      alu_src = ALU_SLT;
      settle();
      check("slt_db", db_reg_data, 64'd1);

      // BEQ x2,x2 not taken at PC 8
      begin_step();
      instruction = enc_b(13'd16, 5'd2, 5'd2, 3'd0);
      carry_in = 1; pc_enable = 1;
      settle();
      check_bit("beq_zero", zero, 1'b1);
      tick();
      mpc = 64'd12;
      check("beq_nt_pc", instruction_address, mpc);

      // PC-relative jump back by -4
      begin_step();
      instruction = enc_b(13'h1FFC, 5'd0, 5'd0, 3'd1);
      pc_src = 1; pc_enable = 1;
      tick();
      mpc = 64'd8;
      check("back_pc", instruction_address, mpc);

      // BEQ taken at PC 8
      begin_step();
      instruction = enc_b(13'd16, 5'd2, 5'd2, 3'd0);
      carry_in = 1; pc_src = 1; pc_enable = 1;
      tick();
      mpc = 64'd24;
      check("beq_t_pc", instruction_address, mpc);

      // ADDI x1,x0,0x101 then JALR x5,x1,4
      begin_step();
      instruction = enc_i(12'h101, 5'd0, 3'd0, 5'd1, OP_IMM);
      alub_src = 1; write_register_enable = 1; pc_enable = 1;
      tick();
      model_write(5'd1, 64'h101); mpc = 64'd28;
      begin_step();
      instruction = enc_i(12'd4, 5'd1, 3'd0, 5'd5, OP_JALR);
      alub_src = 1; alupc_src = 1; pc_src = 1; pc_enable = 1;
      write_register_src = WB_PC4; write_register_enable = 1;
      settle();
      check("jalr_db", db_reg_data, mpc + 64'd4);
      check("jalr_addr", data_address, 64'h105);
      tick();
      model_write(5'd5, mpc + 64'd4); mpc = 64'h104;
      check("jalr_pc", instruction_address, mpc);
      read_reg(5'd5);

      // Loads of every size and extension from address x2+8
      for (int k = 0; k < 7; k++) begin
         begin_step();
         instruction = enc_i(12'd8, 5'd2, 3'd0, 5'd6, OP_LOAD);
         read_data = 64'h1234_5678_9ABC_DE80;
         alub_src = 1; write_register_src = WB_LOAD; read_data_src = load_sel[k];
         settle();
         check($sformatf("load_sel%0d", load_sel[k]), db_reg_data, ref_load(read_data, load_sel[k]));
         check("load_addr", data_address, 64'd11);
         if (k == 0) check("lb_literal", db_reg_data, 64'hFFFF_FFFF_FFFF_FF80);
         if (k == 1) check("lbu_literal", db_reg_data, 64'h80);
      end

      // Store: write_data = rs2, address = rs1 + imm
      begin_step();
      instruction = enc_s(12'h010, 5'd2, 5'd1, 3'b011);
      alub_src = 1;
      settle();
      check("store_wdata", write_data, 64'd3);
      check("store_addr", data_address, 64'h111);
      instruction = enc_s(12'h810, 5'd2, 5'd1, 3'b011);
      write_register_src = WB_IMM;
      settle();
      check("imm_s", db_reg_data, 64'hFFFF_FFFF_FFFF_F810);
      instruction = enc_b(13'h1FFC, 5'd0, 5'd0, 3'd0);
      settle();
      check("imm_b", db_reg_data, 64'hFFFF_FFFF_FFFF_FFFC);
      instruction = 32'hFFFF_FFB3;
      settle();
      check("imm_none", db_reg_data, 64'd0);

      // x1 <- 0x7FFF_FFFF through a doubleword load, then ADDIW x7,x1,1
      begin_step();
      instruction = enc_i(12'd0, 5'd0, 3'd3, 5'd1, OP_LOAD);
      read_data = 64'h7FFF_FFFF; read_data_src = 3'b011;
      write_register_src = WB_LOAD; write_register_enable = 1;
      tick();
      model_write(5'd1, 64'h7FFF_FFFF);
      begin_step();
      instruction = enc_i(12'd1, 5'd1, 3'd0, 5'd7, OP_IMM_32);
      alub_src = 1; aluy_src = 1; write_register_enable = 1;
      settle();
      check("addiw_db", db_reg_data, WORD_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000);
      tick();
      model_write(5'd7, WORD_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000);
      read_reg(5'd7);

      // LUI and AUIPC
      begin_step();
      instruction = enc_u(20'hABCDE, 5'd8, OP_LUI);
      write_register_src = WB_IMM;
      settle();
      check("lui_db", db_reg_data, 64'hFFFF_FFFF_ABCD_E000);
      instruction = enc_u(20'h00001, 5'd10, OP_AUIPC);
      write_register_src = WB_ALU; alua_src = 1; alub_src = 1;
      settle();
      check("auipc_db", db_reg_data, mpc + 64'h1000);

      // JAL x9,+0x800 then JAL x0,-0x100
      begin_step();
      instruction = enc_j(21'h000800, 5'd9);
      pc_src = 1; pc_enable = 1; write_register_src = WB_PC4; write_register_enable = 1;
      settle();
      check("jal_db", db_reg_data, mpc + 64'd4);
      tick();
      model_write(5'd9, mpc + 64'd4); mpc = mpc + 64'h800;
      check("jal_pc", instruction_address, mpc);
      read_reg(5'd9);
      begin_step();
      instruction = enc_j(21'h1FFF00, 5'd0);
      pc_src = 1; pc_enable = 1; write_register_src = WB_PC4; write_register_enable = 1;
      tick();
      mpc = mpc - 64'h100;
      check("jal_neg_pc", instruction_address, mpc);

      // Write to x0 is ignored
      begin_step();
      instruction = enc_i(12'd123, 5'd0, 3'd0, 5'd0, OP_IMM);
      alub_src = 1; write_register_enable = 1;
      settle();
      check("x0_db", db_reg_data, 64'd123);
      tick();
      read_reg(5'd0);

      // Fill x1..x31 with random values through the load path
      for (int r = 1; r < 32; r++) begin
         begin_step();
         instruction = enc_i(12'd0, 5'd0, 3'd3, 5'(r), OP_LOAD);
         read_data = {$urandom, $urandom};
         read_data_src = 3'b011; write_register_src = WB_LOAD; write_register_enable = 1;
         tick();
         model_write(5'(r), read_data);
      end

      // Randomized ALU traffic
      for (int it = 0; it < 40; it++) begin
         int op;
         logic [4:0] r1, r2, rdd, rs2f;
         logic use_imm, wd, sub, co, ov;
         logic [11:0] im;
         logic [63:0] a, b, expv, s;
         op = int'($urandom_range(0, 9));
         r1 = 5'($urandom); r2 = 5'($urandom); rdd = 5'($urandom);
         use_imm = 1'($urandom); wd = 1'($urandom); im = 12'($urandom);
         begin_step();
         instruction = use_imm ? enc_i(im, r1, op_f3(op), rdd, OP_IMM)
                               : enc_r(7'd0, r2, r1, op_f3(op), rdd, OP_REG);
         sub = (op == 1 || op == 3 || op == 4);
         alub_src = use_imm; alu_src = op_f3(op); carry_in = sub;
         arithmetic = (op == 7); aluy_src = wd;
         write_register_enable = 1; pc_enable = 1;
         rs2f = use_imm ? im[4:0] : r2;
         a = mregs[r1];
         b = use_imm ? {{52{im[11]}}, im} : mregs[r2];
         expv = ref_alu(op, a, b, wd & WORD_EN);
         s  = sub ? a - b : a + b;
         co = sub ? (a >= b) : (s < a);
         ov = sub ? (a[63] != b[63] && s[63] != a[63]) : (a[63] == b[63] && s[63] != a[63]);
         settle();
         check($sformatf("rnd%0d_op%0d_db", it, op), db_reg_data, expv);
         check($sformatf("rnd%0d_addr", it), data_address, expv);
         check($sformatf("rnd%0d_wdata", it), write_data, mregs[rs2f]);
         check($sformatf("rnd%0d_flags", it), {60'b0, zero, negative, carry_out, overflow},
               {60'b0, s == 64'd0, s[63], co, ov});
         tick();
         model_write(rdd, expv); mpc = mpc + 64'd4;
         check($sformatf("rnd%0d_pc", it), instruction_address, mpc);
      end

      // Reset dominates both enables
      begin_step();
      reset = 1'b1; pc_enable = 1; write_register_enable = 1; alub_src = 1;
      instruction = enc_i(12'h7FF, 5'd0, 3'd0, 5'd3, OP_IMM);
      tick();
      mpc = '0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      check("rst2_pc", instruction_address, mpc);
      for (int r = 0; r < 32; r++) read_reg(5'(r));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
